uart_keepalive_gen: RTL and testbench
=====================================

Name: uart_keepalive_gen

Overview:
- Transmit-side companion to the receive-side link activity watchdog.
- Sits between the user byte source and the UART transmitter.
- Passes user bytes through a one-entry AXI-stream-style output register.
- When the line has carried no byte for `preset` counts of `cnt_pulse`, injects a heartbeat byte so the far-end watchdog stays in the active state.

Parameters:
- DATA_WIDTH, 8, width of user, heartbeat and output bytes
- HB_CNT_WIDTH, 16, width of the saturating heartbeat counter

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  high-active enable
- preset  input  32  idle timeout, in cnt_pulse ticks
- cnt_pulse  input  1  tick strobe for the idle counter
- hb_data  input  DATA_WIDTH  heartbeat byte value, sampled at injection
- s_data  input  DATA_WIDTH  user byte
- s_valid  input  1  user byte valid
- s_ready  output  1  user byte accepted when s_valid & s_ready
- m_data  output  DATA_WIDTH  byte to UART TX
- m_valid  output  1  output register full
- m_ready  input  1  UART TX accepts m_data
- m_is_hb  output  1  current m_data is a heartbeat
- hb_sent  output  1  one-cycle pulse when a heartbeat transfers (m_valid & m_ready & m_is_hb)
- hb_count  output  HB_CNT_WIDTH  saturating count of heartbeats transferred

Behaviour:
- Reset: rst is asynchronous, active-high. While rst is asserted:
  - m_valid=0, m_is_hb=0, m_data=0, hb_sent=0, hb_count=0
  - idle counter cnt=0
  - s_ready=0 (combinational, forced by rst)
- Output slot:
  - free = ~m_valid | m_ready.
  - s_ready = en & free & ~rst.
- Load priority, evaluated at each clock edge when en=1 and free=1:
  - (1) User byte: if s_valid, load m_data<=s_data, m_is_hb<=0, m_valid<=1.
  - (2) Heartbeat: else if cnt==0, load m_data<=hb_data, m_is_hb<=1, m_valid<=1.
  - (3) Else if m_ready, m_valid<=0.
  - A user byte offered in the same cycle as a timeout always wins; the heartbeat is dropped, not queued.
- Latency:
  - User byte handshaked in cycle N appears on m_valid/m_data in cycle N+1.
  - Back-to-back throughput is 1 byte/cycle when m_ready=1.
- Idle counter, 32-bit:
  - Reload to preset when any of: ~en, m_valid=1, or a load occurs this cycle.
  - Otherwise, on cnt_pulse with cnt>0, cnt<=cnt-1.
  - Otherwise hold; cnt never wraps below 0.
  - Idle time is measured only while the output slot is empty.
  - Heartbeat timing: the first heartbeat is loaded on the edge after cnt reaches 0, i.e. preset cnt_pulse ticks after the slot empties.
- preset==0: cnt stays 0, so a heartbeat is loaded every cycle the slot is free and s_valid=0 (continuous fill stream).
- preset changed on the fly: takes effect at the next reload; the current countdown is unaffected.
- m_valid handshake rules:
  - Once asserted, m_valid, m_data and m_is_hb stay stable until m_ready.
  - No retraction, including when en drops.
- en=0:
  - No new loads; s_ready=0; cnt held at preset.
  - A pending output byte still drains on m_ready.
  - hb_count retains its value.
- hb_sent / hb_count:
  - hb_sent is registered: it asserts the cycle after the heartbeat handshake, for 1 cycle.
  - hb_count increments on the same event and saturates at all-ones.
- Reset mid-transfer: the output byte is discarded immediately; there is no partial state after release.

Test Plan:
- User byte pass-through:
  - Stimulus: en=1, preset=10, s_data=0xA5 with s_valid 1 cycle, m_ready=1.
  - Response: m_valid=1, m_data=0xA5, m_is_hb=0 the next cycle; no heartbeat within 9 cnt_pulses.
- Timeout injection:
  - Stimulus: en=1, preset=4, hb_data=0x55, m_ready=1, cnt_pulse every 3rd cycle, no user data.
  - Response: m_valid with m_data=0x55, m_is_hb=1 after the 4th pulse + 1 cycle; hb_sent pulse; hb_count=1; repeats every 4 pulses.
- Collision:
  - Stimulus: s_valid=1 with s_data=0x11 in the exact cycle cnt==0.
  - Response: 0x11 is emitted with m_is_hb=0; cnt reloads; no heartbeat until preset pulses later.
- Backpressure:
  - Stimulus: heartbeat pending with m_ready=0 for 20 cycles while cnt_pulse toggles.
  - Response: m_data/m_valid stable; s_ready=0; cnt held at preset; single hb_sent after m_ready=1.
- preset=0 and en drop:
  - Stimulus: preset=0, m_ready=1.
  - Response: heartbeat every cycle.
  - Stimulus: deassert en with a byte pending.
  - Response: the byte drains, then m_valid=0 and no further loads.
- Async reset and saturation:
  - Stimulus: assert rst mid-transfer, off the clock edge.
  - Response: m_valid=0, hb_count=0 immediately.
  - Stimulus: force 65536 heartbeats.
  - Response: hb_count=0xFFFF.

Source files
------------

// File: rtl/uart_keepalive_gen.sv
// UART TX keepalive: passes user bytes through a one-entry output
// register and injects a heartbeat byte after an idle timeout.
module uart_keepalive_gen #(
  parameter int DATA_WIDTH   = 8,
  parameter int HB_CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [31:0]             preset,
  input  logic                    cnt_pulse,
  input  logic [DATA_WIDTH-1:0]   hb_data,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_is_hb,
  output logic                    hb_sent,
  output logic [HB_CNT_WIDTH-1:0] hb_count
);

  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    is_hb_q, is_hb_d;
  logic                    sent_q, sent_d;
  logic [HB_CNT_WIDTH-1:0] count_q, count_d;
  logic [31:0]             cnt_q, cnt_d;

  logic free;
  logic load_user;
  logic load_hb;

  assign free      = ~valid_q | m_ready;
  assign load_user = en & free & s_valid;
  assign load_hb   = en & free & ~s_valid & (cnt_q == 32'd0);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    is_hb_d = is_hb_q;
    sent_d  = valid_q & m_ready & is_hb_q;
    count_d = count_q;
    cnt_d   = cnt_q;

    if (load_user) begin
      data_d  = s_data;
      is_hb_d = 1'b0;
      valid_d = 1'b1;
    end else if (load_hb) begin
      data_d  = hb_data;
      is_hb_d = 1'b1;
      valid_d = 1'b1;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end

    if (sent_d && !(&count_q))
      count_d = count_q + 1'b1;

    // Idle time only accrues while the slot is empty and nothing loads.
    if (!en || valid_q || load_user || load_hb)
      cnt_d = preset;
    else if (cnt_pulse && cnt_q != 32'd0)
      cnt_d = cnt_q - 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      is_hb_q <= 1'b0;
      sent_q  <= 1'b0;
      count_q <= '0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      is_hb_q <= is_hb_d;
      sent_q  <= sent_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_ready  = en & free & ~rst;
  assign m_data   = data_q;
  assign m_valid  = valid_q;
  assign m_is_hb  = is_hb_q;
  assign hb_sent  = sent_q;
  assign hb_count = count_q;

endmodule

// File: tb/tb_uart_keepalive_gen.sv
// Bench for uart_keepalive_gen: idle-time model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_uart_keepalive_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] preset;
  logic        cnt_pulse;
  logic [7:0]  hb_data;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_is_hb;
  logic        hb_sent;
  logic [15:0] hb_count;

  int ncmp = 0;
  int nerr = 0;

  uart_keepalive_gen dut (
    .clk(clk), .rst(rst), .en(en), .preset(preset),
    .cnt_pulse(cnt_pulse), .hb_data(hb_data),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_is_hb(m_is_hb), .hb_sent(hb_sent), .hb_count(hb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: slot contents plus idle pulses seen since the slot went idle.
  logic        mv = 0, mhb = 0, msent = 0;
  logic [7:0]  md = 0;
  int unsigned tgt = 0, idle = 0;
  int          mcount = 0;

  always @(posedge clk or posedge rst) begin
    bit fr, lu, lh, busy;
    if (rst) begin
      mv = 0; mhb = 0; md = 0; msent = 0;
      mcount = 0; tgt = 0; idle = 0;
    end else begin
      fr    = !mv || m_ready;
      msent = mv && m_ready && mhb;
      if (msent && mcount < 65535) mcount++;
      lu   = en && fr && s_valid;
      lh   = en && fr && !s_valid && (idle >= tgt);
      busy = !en || mv || lu || lh;
      if (lu) begin
        mv = 1; md = s_data; mhb = 0;
      end else if (lh) begin
        mv = 1; md = hb_data; mhb = 1;
      end else if (m_ready) begin
        mv = 0;
      end
      if (busy) begin
        tgt = preset; idle = 0;
      end else if (cnt_pulse && idle < tgt) begin
        idle++;
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_m_valid", 32'(m_valid), 32'(mv));
    chk("mdl_m_data", 32'(m_data), 32'(md));
    chk("mdl_m_is_hb", 32'(m_is_hb), 32'(mhb));
    chk("mdl_hb_sent", 32'(hb_sent), 32'(msent));
    chk("mdl_hb_count", 32'(hb_count), 32'(mcount));
    chk("mdl_s_ready", 32'(s_ready),
        32'(en && (!mv || m_ready) && !rst));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; en = 0; preset = 10; cnt_pulse = 0;
    hb_data = 8'h55; s_data = 0; s_valid = 0; m_ready = 1;
    tick(); tick();
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_hb_count", 32'(hb_count), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    rst = 0;
    tick();

    // pass-through
    en = 1; s_valid = 1; s_data = 8'hA5;
    tick();
    s_valid = 0;
    chk("pt_m_valid", 32'(m_valid), 1);
    chk("pt_m_data", 32'(m_data), 32'hA5);
    chk("pt_m_is_hb", 32'(m_is_hb), 0);
    tick();
    for (int i = 0; i < 9; i++) begin
      cnt_pulse = 1; tick();
      cnt_pulse = 0; tick();
      chk("pt_no_hb", 32'(m_valid), 0);
    end

    // timeout injection, pulse every 3rd cycle
    en = 0; preset = 4; tick();
    en = 1;
    for (int k = 0; k <= 25; k++) begin
      cnt_pulse = (k % 3 == 2);
      tick();
      if (k == 11) chk("to_before", 32'(m_valid), 0);
      if (k == 12) begin
        chk("to_valid", 32'(m_valid), 1);
        chk("to_data", 32'(m_data), 32'h55);
        chk("to_is_hb", 32'(m_is_hb), 1);
      end
      if (k == 13) begin
        chk("to_sent", 32'(hb_sent), 1);
        chk("to_count1", 32'(hb_count), 1);
      end
    end
    chk("to_count2", 32'(hb_count), 2);

    // collision at cnt==0
    for (int i = 0; i < 4; i++) begin
      cnt_pulse = 1; tick();
    end
    cnt_pulse = 0; s_valid = 1; s_data = 8'h11;
    tick();
    s_valid = 0;
    chk("col_data", 32'(m_data), 32'h11);
    chk("col_is_hb", 32'(m_is_hb), 0);
    for (int i = 0; i < 4; i++) begin
      cnt_pulse = 1; tick();
      chk("col_no_hb", 32'(m_valid), 0);
    end
    chk("col_count", 32'(hb_count), 2);

    // backpressure on a pending heartbeat
    tick();
    cnt_pulse = 0; m_ready = 0;
    tick();
    s_valid = 1; s_data = 8'h77;
    for (int i = 0; i < 20; i++) begin
      cnt_pulse = i[0];
      tick();
      chk("bp_valid", 32'(m_valid), 1);
      chk("bp_data", 32'(m_data), 32'h55);
      chk("bp_s_ready", 32'(s_ready), 0);
    end
    s_valid = 0; cnt_pulse = 0; m_ready = 1;
    tick();
    chk("bp_sent", 32'(hb_sent), 1);
    chk("bp_count", 32'(hb_count), 3);
    chk("bp_drained", 32'(m_valid), 0);
    tick();
    chk("bp_sent_once", 32'(hb_sent), 0);

    // preset 0: continuous heartbeat stream
    en = 0; preset = 0; tick();
    en = 1;
    repeat (5) tick();
    chk("p0_count", 32'(hb_count), 7);
    chk("p0_valid", 32'(m_valid), 1);

    // en drop with byte pending
    m_ready = 0; en = 0;
    tick();
    chk("en_hold", 32'(m_valid), 1);
    chk("en_s_ready", 32'(s_ready), 0);
    m_ready = 1;
    tick();
    chk("en_drain", 32'(m_valid), 0);
    chk("en_count", 32'(hb_count), 8);
    repeat (3) tick();
    chk("en_noload", 32'(m_valid), 0);

    // async reset mid-transfer
    en = 1; m_ready = 0;
    tick();
    #3 rst = 1;
    #1;
    chk("ar_valid", 32'(m_valid), 0);
    chk("ar_count", 32'(hb_count), 0);
    chk("ar_is_hb", 32'(m_is_hb), 0);
    tick();
    rst = 0; m_ready = 1;

    // saturation
    repeat (65540) tick();
    chk("sat_count", 32'(hb_count), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
